pio_reg_endpoint: RTL and testbench

PCIe programmed-I/O target for the 64-bit Xilinx 7-series AXI4-Stream TLP interface. It accepts single-DW 32-bit-address memory reads and writes to a small BAR register file. It returns one CplD per read and exports the NUMA-bridge network registers (local/destination IPv4 and MAC) to the Ethernet datapath. XGMII framing is a separate block.

---
 rtl/pio_reg_endpoint.sv | 176 +++++++++++++++++
 tb/tb_pio_reg_endpoint.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_reg_endpoint.sv
// PCIe PIO target on the 64-bit 7-series AXI4-Stream TLP interface: single-DW MRd32/MWr32
// into a small BAR register file holding the NUMA-bridge network addresses, one CplD per read.
module pio_reg_endpoint (
  input  logic        user_clk,
  input  logic        user_reset_n,
  input  logic        user_lnk_up,
  input  logic        s_axis_tx_tready,
  output logic [63:0] s_axis_tx_tdata,
  output logic [7:0]  s_axis_tx_tkeep,
  output logic        s_axis_tx_tlast,
  output logic        s_axis_tx_tvalid,
  output logic        tx_src_dsc,
  input  logic [63:0] m_axis_rx_tdata,
  input  logic [7:0]  m_axis_rx_tkeep,
  input  logic        m_axis_rx_tlast,
  input  logic        m_axis_rx_tvalid,
  output logic        m_axis_rx_tready,
  input  logic [21:0] m_axis_rx_tuser,
  input  logic        cfg_to_turnoff,
  output logic        cfg_turnoff_ok,
  input  logic [15:0] cfg_completer_id,
  output logic [31:0] if_v4addr,
  output logic [47:0] if_macaddr,
  output logic [31:0] dest_v4addr,
  output logic [47:0] dest_macaddr
);

  localparam logic [31:0] ID_VALUE = 32'h4950_4E4D;

  typedef enum logic [1:0] {RX_HDR, RX_BODY, RX_DROP, RX_WAIT} rx_state_t;

  rx_state_t   state, state_nxt;
  logic        rdy_q;
  logic        rx_fire, tx_fire, hdr_ok, wr_commit, rd_start;
  logic        is_wr;
  logic [2:0]  tc;
  logic [1:0]  attr;
  logic [15:0] req_id;
  logic [7:0]  tag;
  logic [3:0]  first_be;
  logic [4:0]  offset;
  logic [31:0] sw_data, rd_data, if_mac_hi_new, dest_mac_hi_new;
  logic [63:0] cpl_b1;
  logic        unused_ok;

  function automatic logic [31:0] swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // firstBE[i] enables the i-th payload byte, which lands in the i-th byte from the MSB after the swap
  function automatic logic [31:0] be_merge(input logic [31:0] cur, input logic [31:0] nw,
                                           input logic [3:0] be);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++)
      if (be[i]) res[31-8*i -: 8] = nw[31-8*i -: 8];
    return res;
  endfunction

  assign tx_src_dsc       = 1'b0;
  assign m_axis_rx_tready = rdy_q & user_lnk_up & (state != RX_WAIT);
  assign rx_fire          = m_axis_rx_tvalid & m_axis_rx_tready;
  assign tx_fire          = s_axis_tx_tvalid & s_axis_tx_tready;
  assign hdr_ok           = ((m_axis_rx_tdata[30:24] == 7'h00) || (m_axis_rx_tdata[30:24] == 7'h40)) &&
                            (m_axis_rx_tdata[9:0] == 10'd1) && !m_axis_rx_tlast;
  assign wr_commit        = (state == RX_BODY) & rx_fire & is_wr;
  assign rd_start         = (state == RX_BODY) & rx_fire & ~is_wr;
  assign offset           = m_axis_rx_tdata[6:2];
  assign sw_data          = swap32(m_axis_rx_tdata[63:32]);
  assign if_mac_hi_new    = be_merge({16'h0, if_macaddr[47:32]}, sw_data, first_be);
  assign dest_mac_hi_new  = be_merge({16'h0, dest_macaddr[47:32]}, sw_data, first_be);
  assign unused_ok        = ^{m_axis_rx_tuser, m_axis_rx_tkeep, m_axis_rx_tdata,
                              if_mac_hi_new[31:16], dest_mac_hi_new[31:16]};

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state <= RX_HDR;
      rdy_q <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX_HDR:  if (rx_fire) begin
                 if (hdr_ok)                state_nxt = RX_BODY;
                 else if (!m_axis_rx_tlast) state_nxt = RX_DROP;
               end
      RX_BODY: if (rx_fire) state_nxt = is_wr ? RX_HDR : RX_WAIT;
      RX_DROP: if (rx_fire && m_axis_rx_tlast) state_nxt = RX_HDR;
      RX_WAIT: if (tx_fire && s_axis_tx_tlast) state_nxt = RX_HDR;
      default: state_nxt = RX_HDR;
    endcase
  end

  // header fields are only consumed in RX_BODY, so they need no reset
  always_ff @(posedge user_clk) begin
    if (state == RX_HDR && rx_fire) begin
      is_wr    <= m_axis_rx_tdata[30];
      tc       <= m_axis_rx_tdata[22:20];
      attr     <= m_axis_rx_tdata[13:12];
      req_id   <= m_axis_rx_tdata[63:48];
      tag      <= m_axis_rx_tdata[47:40];
      first_be <= m_axis_rx_tdata[35:32];
    end
  end

  always_comb begin
    rd_data = 32'h0;
    case (offset)
      5'd0: rd_data = if_v4addr;
      5'd1: rd_data = if_macaddr[31:0];
      5'd2: rd_data = {16'h0, if_macaddr[47:32]};
      5'd3: rd_data = dest_v4addr;
      5'd4: rd_data = dest_macaddr[31:0];
      5'd5: rd_data = {16'h0, dest_macaddr[47:32]};
      5'd6: rd_data = ID_VALUE;
      default: rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      if_v4addr    <= 32'h0A00_0001;
      if_macaddr   <= 48'h0037_7600_0001;
      dest_v4addr  <= 32'h0A00_0002;
      dest_macaddr <= 48'hFFFF_FFFF_FFFF;
    end else if (wr_commit) begin
      case (offset)
        5'd0: if_v4addr           <= be_merge(if_v4addr, sw_data, first_be);
        5'd1: if_macaddr[31:0]    <= be_merge(if_macaddr[31:0], sw_data, first_be);
        5'd2: if_macaddr[47:32]   <= if_mac_hi_new[15:0];
        5'd3: dest_v4addr         <= be_merge(dest_v4addr, sw_data, first_be);
        5'd4: dest_macaddr[31:0]  <= be_merge(dest_macaddr[31:0], sw_data, first_be);
        5'd5: dest_macaddr[47:32] <= dest_mac_hi_new[15:0];
        default: ;
      endcase
    end
  end

  // completion beat 1 is built at the accepting edge so the read sees every earlier write
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      s_axis_tx_tvalid <= 1'b0;
      s_axis_tx_tdata  <= 64'h0;
      s_axis_tx_tkeep  <= 8'h0;
      s_axis_tx_tlast  <= 1'b0;
      cpl_b1           <= 64'h0;
    end else if (rd_start) begin
      s_axis_tx_tvalid <= 1'b1;
      s_axis_tx_tdata  <= {cfg_completer_id, 3'b000, 1'b0, 12'd4,
                           1'b0, 2'b10, 5'b01010, 1'b0, tc, 4'b0, 1'b0, 1'b0, attr, 2'b00, 10'd1};
      s_axis_tx_tkeep  <= 8'hFF;
      s_axis_tx_tlast  <= 1'b0;
      cpl_b1           <= {swap32(rd_data), req_id, tag, 1'b0, offset, 2'b00};
    end else if (tx_fire) begin
      if (s_axis_tx_tlast) begin
        s_axis_tx_tvalid <= 1'b0;
        s_axis_tx_tlast  <= 1'b0;
      end else begin
        s_axis_tx_tdata  <= cpl_b1;
        s_axis_tx_tlast  <= 1'b1;
      end
    end
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) cfg_turnoff_ok <= 1'b0;
    else cfg_turnoff_ok <= cfg_to_turnoff && (state != RX_BODY) && (state != RX_WAIT) &&
                           !s_axis_tx_tvalid;
  end

endmodule

// File: tb/tb_pio_reg_endpoint.sv
// Randomized bench for pio_reg_endpoint: TLPs driven on RX, completions collected on TX and
// compared against a register-map model built from byte-level write rules.
module tb_pio_reg_endpoint;
  logic        user_clk = 1'b0;
  logic        user_reset_n, user_lnk_up, s_axis_tx_tready;
  logic [63:0] s_axis_tx_tdata;
  logic [7:0]  s_axis_tx_tkeep;
  logic        s_axis_tx_tlast, s_axis_tx_tvalid, tx_src_dsc;
  logic [63:0] m_axis_rx_tdata;
  logic [7:0]  m_axis_rx_tkeep;
  logic        m_axis_rx_tlast, m_axis_rx_tvalid, m_axis_rx_tready;
  logic [21:0] m_axis_rx_tuser;
  logic        cfg_to_turnoff, cfg_turnoff_ok;
  logic [15:0] cfg_completer_id;
  logic [31:0] if_v4addr, dest_v4addr;
  logic [47:0] if_macaddr, dest_macaddr;

  int checks = 0;
  int failures = 0;
  logic [31:0] mreg [0:6];

  always #5 user_clk = ~user_clk;

  pio_reg_endpoint dut (
    .user_clk(user_clk), .user_reset_n(user_reset_n), .user_lnk_up(user_lnk_up),
    .s_axis_tx_tready(s_axis_tx_tready), .s_axis_tx_tdata(s_axis_tx_tdata),
    .s_axis_tx_tkeep(s_axis_tx_tkeep), .s_axis_tx_tlast(s_axis_tx_tlast),
    .s_axis_tx_tvalid(s_axis_tx_tvalid), .tx_src_dsc(tx_src_dsc),
    .m_axis_rx_tdata(m_axis_rx_tdata), .m_axis_rx_tkeep(m_axis_rx_tkeep),
    .m_axis_rx_tlast(m_axis_rx_tlast), .m_axis_rx_tvalid(m_axis_rx_tvalid),
    .m_axis_rx_tready(m_axis_rx_tready), .m_axis_rx_tuser(m_axis_rx_tuser),
    .cfg_to_turnoff(cfg_to_turnoff), .cfg_turnoff_ok(cfg_turnoff_ok),
    .cfg_completer_id(cfg_completer_id), .if_v4addr(if_v4addr), .if_macaddr(if_macaddr),
    .dest_v4addr(dest_v4addr), .dest_macaddr(dest_macaddr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [31:0] mk_h0(input logic [6:0] ft, input logic [2:0] tc,
                                        input logic [1:0] attr, input logic [9:0] len);
    return {1'b0, ft, 1'b0, tc, 6'b0, attr, 2'b00, len};
  endfunction

  function automatic logic [31:0] mk_h1(input logic [15:0] rid, input logic [7:0] tg,
                                        input logic [3:0] be);
    return {rid, tg, 4'b0000, be};
  endfunction

  task automatic model_reset();
    mreg[0] = 32'h0A000001; mreg[1] = 32'h76000001; mreg[2] = 32'h00000037;
    mreg[3] = 32'h0A000002; mreg[4] = 32'hFFFFFFFF; mreg[5] = 32'h0000FFFF;
    mreg[6] = 32'h49504E4D;
  endtask

  // payload byte i (d[8i+7:8i]) becomes register byte i counted from the MSB
  task automatic model_write(input logic [4:0] off, input logic [31:0] d, input logic [3:0] be);
    if (off <= 5) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mreg[off][31-8*i -: 8] = d[8*i +: 8];
      if (off == 2 || off == 5) mreg[off][31:16] = 16'h0;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] off);
    return (off <= 6) ? mreg[off] : 32'h0;
  endfunction

  task automatic check_regs(input string tag);
    chk({tag, "_if_v4"}, {32'h0, if_v4addr}, {32'h0, mreg[0]});
    chk({tag, "_if_mac"}, {16'h0, if_macaddr}, {16'h0, mreg[2][15:0], mreg[1]});
    chk({tag, "_dst_v4"}, {32'h0, dest_v4addr}, {32'h0, mreg[3]});
    chk({tag, "_dst_mac"}, {16'h0, dest_macaddr}, {16'h0, mreg[5][15:0], mreg[4]});
  endtask

  task automatic rx_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input int gap);
    int n = 0;
    for (int g = 0; g < gap; g++) begin
      @(negedge user_clk);
      m_axis_rx_tvalid = 1'b0;
    end
    @(negedge user_clk);
    m_axis_rx_tdata = d; m_axis_rx_tkeep = k; m_axis_rx_tlast = l; m_axis_rx_tvalid = 1'b1;
    while (!m_axis_rx_tready && n < 200) begin
      @(negedge user_clk);
      n++;
    end
    if (!m_axis_rx_tready) chk("rx_accept_timeout", {63'h0, m_axis_rx_tready}, 64'h1);
    @(posedge user_clk);
  endtask

  task automatic collect_cpl(input logic [63:0] e0, input logic [63:0] e1, input int hold);
    logic [63:0] held_d;
    logic done;
    int n;
    int hold_left = hold;
    @(negedge user_clk);
    m_axis_rx_tvalid = 1'b0;
    chk("cpl_latency", {63'h0, s_axis_tx_tvalid}, 64'h1);
    for (int b = 0; b < 2; b++) begin
      held_d = s_axis_tx_tdata;
      n = 0;
      done = 1'b0;
      while (!done && n < 400) begin
        if (n > 0) begin
          chk("tx_hold_data", s_axis_tx_tdata, held_d);
          chk("tx_hold_vld", {63'h0, s_axis_tx_tvalid}, 64'h1);
        end
        chk("rx_rdy_wait", {63'h0, m_axis_rx_tready}, 64'h0);
        chk("turnoff_busy", {63'h0, cfg_turnoff_ok}, 64'h0);
        if (hold_left > 0) begin
          s_axis_tx_tready = 1'b0;
          hold_left--;
        end else s_axis_tx_tready = ($urandom_range(0, 2) != 0);
        if (s_axis_tx_tready && s_axis_tx_tvalid) begin
          chk(b ? "cpl_beat1" : "cpl_beat0", s_axis_tx_tdata, b ? e1 : e0);
          chk("cpl_keep", {56'h0, s_axis_tx_tkeep}, 64'hFF);
          chk("cpl_last", {63'h0, s_axis_tx_tlast}, b);
          done = 1'b1;
        end
        @(negedge user_clk);
        n++;
      end
      if (!done) chk("tx_timeout", {63'h0, s_axis_tx_tvalid}, 64'h2);
    end
    chk("tx_idle", {63'h0, s_axis_tx_tvalid}, 64'h0);
  endtask

  task automatic send_wr(input logic [4:0] off, input logic [31:0] d, input logic [3:0] be, input int gap);
    logic [24:0] hi;
    hi = 25'($urandom);
    rx_beat({mk_h1(16'($urandom), 8'($urandom), be), mk_h0(7'h40, 3'($urandom), 2'($urandom), 10'd1)},
            8'hFF, 1'b0, gap);
    rx_beat({d, hi, off, 2'b00}, 8'hFF, 1'b1, gap);
    model_write(off, d, be);
    @(negedge user_clk);
    m_axis_rx_tvalid = 1'b0;
    check_regs("wr");
  endtask

  task automatic send_rd(input logic [4:0] off, input logic [15:0] rid, input logic [7:0] tg,
                         input logic [2:0] tc, input logic [1:0] attr, input int gap, input int hold);
    logic [63:0] e0, e1;
    e0 = {cfg_completer_id, 3'b000, 1'b0, 12'd4, 1'b0, 2'b10, 5'b01010, 1'b0, tc, 4'b0, 2'b00,
          attr, 2'b00, 10'd1};
    e1 = {bswap(model_read(off)), rid, tg, 1'b0, off, 2'b00};
    rx_beat({mk_h1(rid, tg, 4'hF), mk_h0(7'h00, tc, attr, 10'd1)}, 8'hFF, 1'b0, gap);
    rx_beat({32'h0, 25'($urandom), off, 2'b00}, 8'h0F, 1'b1, gap);
    collect_cpl(e0, e1, hold);
  endtask

  task automatic send_drop();
    logic [6:0] ft;
    logic [9:0] len;
    int nb;
    case ($urandom_range(0, 5))
      0: ft = 7'h60;
      1: ft = 7'h20;
      2: ft = 7'h30;
      3: ft = 7'h04;
      4: ft = 7'h00;
      default: ft = 7'h40;
    endcase
    len = (ft == 7'h00 || ft == 7'h40) ? 10'($urandom_range(2, 1023)) : 10'($urandom_range(0, 1023));
    nb = $urandom_range(1, 4);
    rx_beat({mk_h1(16'($urandom), 8'($urandom), 4'hF), mk_h0(ft, 3'($urandom), 2'($urandom), len)},
            8'hFF, nb == 1, 0);
    for (int i = 1; i < nb; i++)
      rx_beat({$urandom, 32'h0, 25'($urandom), 5'($urandom), 2'b00}, 8'hFF, i == nb - 1, $urandom_range(0, 1));
    @(negedge user_clk);
    m_axis_rx_tvalid = 1'b0;
    chk("drop_no_tx", {63'h0, s_axis_tx_tvalid}, 64'h0);
    check_regs("drop");
  endtask

  initial begin
    logic [4:0] off;
    int kind;
    user_reset_n = 1'b0; user_lnk_up = 1'b1; s_axis_tx_tready = 1'b1;
    m_axis_rx_tdata = '0; m_axis_rx_tkeep = '0; m_axis_rx_tlast = 1'b0; m_axis_rx_tvalid = 1'b0;
    m_axis_rx_tuser = '0; cfg_to_turnoff = 1'b0; cfg_completer_id = 16'h0210;
    model_reset();
    repeat (3) @(negedge user_clk);
    chk("rst_tx_vld", {63'h0, s_axis_tx_tvalid}, 64'h0);
    chk("rst_rx_rdy", {63'h0, m_axis_rx_tready}, 64'h0);
    chk("rst_tx_data", s_axis_tx_tdata, 64'h0);
    chk("rst_turnoff", {63'h0, cfg_turnoff_ok}, 64'h0);
    user_reset_n = 1'b1;
    @(negedge user_clk);
    chk("rst_if_v4", {32'h0, if_v4addr}, 64'h0A000001);
    chk("rst_dst_mac", {16'h0, dest_macaddr}, 64'hFFFFFFFFFFFF);
    chk("rel_rx_rdy", {63'h0, m_axis_rx_tready}, 64'h1);
    chk("rel_dsc", {63'h0, tx_src_dsc}, 64'h0);
    check_regs("rst");

    // directed scenarios
    send_wr(5'h03, 32'h0200000A, 4'hF, 0);
    chk("dir_dst_v4", {32'h0, dest_v4addr}, 64'h0A000002);
    rx_beat({mk_h1(16'h0100, 8'h05, 4'hF), mk_h0(7'h00, 3'd0, 2'd0, 10'd1)}, 8'hFF, 1'b0, 0);
    rx_beat({32'h0, 32'h00000018}, 8'h0F, 1'b1, 0);
    collect_cpl(64'h02100004_4A000001, 64'h4D4E5049_01000518, 0);
    send_wr(5'h00, 32'hFFFFFFFF, 4'h1, 0);
    chk("dir_be1", {32'h0, if_v4addr}, 64'hFF000001);
    rx_beat({mk_h1(16'h1234, 8'h77, 4'hF), mk_h0(7'h60, 3'd0, 2'd0, 10'd1)}, 8'hFF, 1'b0, 0);
    rx_beat({32'h00000000, 32'h00000000}, 8'hFF, 1'b0, 0);
    rx_beat({32'h11111111, 32'h22222222}, 8'hFF, 1'b0, 0);
    rx_beat({32'h33333333, 32'h44444444}, 8'hFF, 1'b1, 0);
    send_rd(5'h00, 16'hABCD, 8'h3C, 3'd2, 2'd1, 0, 0);
    check_regs("after_mwr64");
    cfg_to_turnoff = 1'b1;
    send_rd(5'h04, 16'h0042, 8'h9A, 3'd5, 2'd3, 0, 10);
    chk("turnoff_reg_lat", {63'h0, cfg_turnoff_ok}, 64'h0);
    @(negedge user_clk);
    chk("turnoff_grant", {63'h0, cfg_turnoff_ok}, 64'h1);
    cfg_to_turnoff = 1'b0;

    // randomized traffic
    for (int t = 0; t < 120; t++) begin
      kind = $urandom_range(0, 9);
      off = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      if (kind <= 3) send_wr(off, $urandom, 4'($urandom), $urandom_range(0, 2));
      else if (kind <= 6) begin
        if ($urandom_range(0, 3) == 0) cfg_completer_id = 16'($urandom);
        send_rd(off, 16'($urandom), 8'($urandom), 3'($urandom), 2'($urandom), $urandom_range(0, 2),
                $urandom_range(0, 3));
      end else if (kind <= 8) send_drop();
      else begin
        @(negedge user_clk);
        user_lnk_up = 1'b0;
        @(negedge user_clk);
        chk("lnk_down_rdy", {63'h0, m_axis_rx_tready}, 64'h0);
        check_regs("lnk_down");
        user_lnk_up = 1'b1;
        @(negedge user_clk);
        chk("lnk_up_rdy", {63'h0, m_axis_rx_tready}, 64'h1);
      end
    end

    // reset in the middle of a completion
    send_wr(5'h00, 32'h44332211, 4'hF, 0);
    rx_beat({mk_h1(16'h0001, 8'h01, 4'hF), mk_h0(7'h00, 3'd0, 2'd0, 10'd1)}, 8'hFF, 1'b0, 0);
    rx_beat({32'h0, 32'h00000000}, 8'h0F, 1'b1, 0);
    @(negedge user_clk);
    m_axis_rx_tvalid = 1'b0;
    s_axis_tx_tready = 1'b0;
    chk("mid_pre_vld", {63'h0, s_axis_tx_tvalid}, 64'h1);
    #2 user_reset_n = 1'b0;
    #1;
    chk("mid_rst_vld", {63'h0, s_axis_tx_tvalid}, 64'h0);
    chk("mid_rst_v4", {32'h0, if_v4addr}, 64'h0A000001);
    chk("mid_rst_rdy", {63'h0, m_axis_rx_tready}, 64'h0);
    @(negedge user_clk);
    user_reset_n = 1'b1;
    model_reset();
    @(negedge user_clk);
    s_axis_tx_tready = 1'b1;
    chk("mid_rel_rdy", {63'h0, m_axis_rx_tready}, 64'h1);
    check_regs("mid_rel");
    send_rd(5'h06, 16'h0100, 8'h05, 3'd0, 2'd0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
